// File: rtl/wishbone_arbiter2_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wishbone_arbiter2_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_M0   = 2'b01,
        ARB_M1   = 2'b10
    } arb_state_e;

    localparam int          ARB_TIMEOUT_DEFAULT = 16;
    localparam int          ARB_CNT_W_DEFAULT   = 5;
    localparam logic [31:0] ZERO_WORD           = 32'h0000_0000;

    // One-hot owner vector for a given arbiter state (bit0 = m0, bit1 = m1).
    function automatic logic [1:0] grant_of(input arb_state_e st);
        logic [1:0] g;
        case (st)
            ARB_M0:  g = 2'b01;
            ARB_M1:  g = 2'b10;
            default: g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/wishbone_arbiter2_if.sv
// Wishbone classic bus bundle. "master" is the initiator view, "slave" the target view.
interface wishbone_arbiter2_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, sel, addr, dat_w,
        input  dat_r, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, addr, dat_w,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wishbone_arbiter2_wb_watchdog.sv
// Counts strobe cycles without acknowledge and pulses err when the slave is
// considered dead. TIMEOUT = 0 disables the err pulse entirely.
module wishbone_arbiter2_wb_watchdog #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic stb,
    input  logic ack,
    input  logic clr,
    output logic err
);

    localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] wd_cnt_q;
    logic [CNT_W-1:0] wd_cnt_d;
    logic             expire;

    // Next count: restart on ack, idle strobe, grant change or expiry; else count up.
    always_comb begin
        expire = (TIMEOUT != 0) && stb && !ack && (wd_cnt_q == LIMIT);
        if (clr || !stb || ack || expire) begin
            wd_cnt_d = '0;
        end else begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q <= '0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign err = expire;

endmodule

// File: rtl/wishbone_arbiter2.sv
// Two-master, one-slave Wishbone arbiter. Grant is held for a whole CYC,
// ties are broken round-robin, and a watchdog turns a missing ACK into ERR.
module wishbone_arbiter2
    import wishbone_arbiter2_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT_DEFAULT,
    parameter int CNT_W   = ARB_CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    wishbone_arbiter2_if.slave   m0,
    wishbone_arbiter2_if.slave   m1,
    wishbone_arbiter2_if.master  s,
    output logic [1:0]           grant_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_grant_q;
    logic       last_grant_d;
    logic       wd_err;

    // State register; last_grant resets to 1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Next-state: hold while the owner keeps CYC, hand off directly on release.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ARB_IDLE: begin
                if (m0.cyc && m1.cyc) begin
                    state_d = last_grant_q ? ARB_M0 : ARB_M1;
                end else if (m0.cyc) begin
                    state_d = ARB_M0;
                end else if (m1.cyc) begin
                    state_d = ARB_M1;
                end
            end
            ARB_M0: begin
                if (!m0.cyc) begin
                    last_grant_d = 1'b0;
                    state_d      = m1.cyc ? ARB_M1 : ARB_IDLE;
                end
            end
            ARB_M1: begin
                if (!m1.cyc) begin
                    last_grant_d = 1'b1;
                    state_d      = m0.cyc ? ARB_M0 : ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Slave-side forwarding of the owner's request; all zero when idle.
    always_comb begin
        s.cyc   = 1'b0;
        s.stb   = 1'b0;
        s.we    = 1'b0;
        s.sel   = 4'h0;
        s.addr  = ZERO_WORD;
        s.dat_w = ZERO_WORD;
        case (state_q)
            ARB_M0: begin
                s.cyc   = m0.cyc;
                s.stb   = m0.stb;
                s.we    = m0.we;
                s.sel   = m0.sel;
                s.addr  = m0.addr;
                s.dat_w = m0.dat_w;
            end
            ARB_M1: begin
                s.cyc   = m1.cyc;
                s.stb   = m1.stb;
                s.we    = m1.we;
                s.sel   = m1.sel;
                s.addr  = m1.addr;
                s.dat_w = m1.dat_w;
            end
            default: ;
        endcase
    end

    // Master-side responses: only the owner with an open cycle sees ack/err/data.
    always_comb begin
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.dat_r = ZERO_WORD;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.dat_r = ZERO_WORD;
        case (state_q)
            ARB_M0: begin
                m0.ack   = s.ack & m0.cyc & m0.stb;
                m0.err   = wd_err & m0.cyc;
                m0.dat_r = s.dat_r;
            end
            ARB_M1: begin
                m1.ack   = s.ack & m1.cyc & m1.stb;
                m1.err   = wd_err & m1.cyc;
                m1.dat_r = s.dat_r;
            end
            default: ;
        endcase
    end

    wishbone_arbiter2_wb_watchdog #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_wb_watchdog (
        .clk (clk),
        .rst (rst),
        .stb (s.stb),
        .ack (s.ack),
        .clr (state_d != state_q),
        .err (wd_err)
    );

    assign grant_o = grant_of(state_q);

endmodule

// File: tb/tb_wishbone_arbiter2.sv
// Directed self-checking bench for wishbone_arbiter2.
module tb_wishbone_arbiter2;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    wishbone_arbiter2_if m0_if ();
    wishbone_arbiter2_if m1_if ();
    wishbone_arbiter2_if s_if ();

    wishbone_arbiter2 #(
        .TIMEOUT (16),
        .CNT_W   (5)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0      (m0_if),
        .m1      (m1_if),
        .s       (s_if),
        .grant_o (grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic m0_drive(input logic cyc, input logic stb, input logic we,
                            input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] dat);
        m0_if.cyc = cyc; m0_if.stb = stb; m0_if.we = we;
        m0_if.sel = sel; m0_if.addr = addr; m0_if.dat_w = dat;
    endtask

    task automatic m1_drive(input logic cyc, input logic stb, input logic we,
                            input logic [3:0] sel, input logic [31:0] addr, input logic [31:0] dat);
        m1_if.cyc = cyc; m1_if.stb = stb; m1_if.we = we;
        m1_if.sel = sel; m1_if.addr = addr; m1_if.dat_w = dat;
    endtask

    task automatic slave_drive(input logic ack, input logic [31:0] dat);
        s_if.ack = ack; s_if.dat_r = dat; s_if.err = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        m0_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        m1_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        slave_drive(0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rst_grant got %b want 00", grant); end
        checks++; if (s_if.cyc !== 1'b0) begin errors++; $display("FAIL rst_s_cyc got %b want 0", s_if.cyc); end
        checks++; if (s_if.addr !== 32'h0) begin errors++; $display("FAIL rst_s_addr got %h want 0", s_if.addr); end
        checks++; if (m0_if.ack !== 1'b0 || m1_if.err !== 1'b0) begin errors++; $display("FAIL rst_resp got %b%b want 00", m0_if.ack, m1_if.err); end
    endtask

    task automatic test_single_read();
        m1_drive(1, 1, 0, 4'hF, 32'h0000_0100, 32'h0);
        settle();
        checks++; if (s_if.cyc !== 1'b0 || grant !== 2'b00) begin errors++; $display("FAIL t1_latency got cyc=%b grant=%b want 0/00", s_if.cyc, grant); end
        tick();
        settle();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL t1_grant got %b want 10", grant); end
        checks++; if (s_if.addr !== 32'h100 || s_if.cyc !== 1'b1 || s_if.stb !== 1'b1) begin errors++; $display("FAIL t1_fwd got addr=%h cyc=%b stb=%b want 100/1/1", s_if.addr, s_if.cyc, s_if.stb); end
        tick();
        settle();
        checks++; if (m1_if.ack !== 1'b0) begin errors++; $display("FAIL t1_early_ack got %b want 0", m1_if.ack); end
        tick();
        slave_drive(1, 32'h1234_5678);
        settle();
        checks++; if (m1_if.ack !== 1'b1) begin errors++; $display("FAIL t1_ack got %b want 1", m1_if.ack); end
        checks++; if (m1_if.dat_r !== 32'h1234_5678) begin errors++; $display("FAIL t1_data got %h want 12345678", m1_if.dat_r); end
        checks++; if (m0_if.ack !== 1'b0 || m0_if.dat_r !== 32'h0) begin errors++; $display("FAIL t1_m0_quiet got ack=%b data=%h want 0/0", m0_if.ack, m0_if.dat_r); end
        tick();
        slave_drive(0, 32'h0);
        m1_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        settle();
        checks++; if (m1_if.ack !== 1'b0 || s_if.cyc !== 1'b0) begin errors++; $display("FAIL t1_release got ack=%b cyc=%b want 0/0", m1_if.ack, s_if.cyc); end
        tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t1_idle got %b want 00", grant); end
    endtask

    task automatic test_round_robin();
        apply_reset();
        m0_drive(1, 1, 0, 4'hF, 32'h200, 32'h0);
        m1_drive(1, 1, 0, 4'hF, 32'h300, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b01 || s_if.addr !== 32'h200) begin errors++; $display("FAIL t2_first got grant=%b addr=%h want 01/200", grant, s_if.addr); end
        slave_drive(1, 32'hCAFE_F00D);
        settle();
        checks++; if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0 || m1_if.dat_r !== 32'h0) begin errors++; $display("FAIL t2_ack_steer got m0=%b m1=%b d1=%h want 1/0/0", m0_if.ack, m1_if.ack, m1_if.dat_r); end
        tick();
        slave_drive(0, 32'h0);
        m0_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        settle();
        checks++; if (s_if.cyc !== 1'b0 || grant !== 2'b01) begin errors++; $display("FAIL t2_drop got cyc=%b grant=%b want 0/01", s_if.cyc, grant); end
        tick();
        settle();
        checks++; if (grant !== 2'b10 || s_if.addr !== 32'h300) begin errors++; $display("FAIL t2_handoff got grant=%b addr=%h want 10/300", grant, s_if.addr); end
        m0_drive(1, 1, 0, 4'hF, 32'h204, 32'h0);
        m1_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b01 || s_if.addr !== 32'h204) begin errors++; $display("FAIL t2_handback got grant=%b addr=%h want 01/204", grant, s_if.addr); end
        m0_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t2_idle got %b want 00", grant); end
        m0_drive(1, 1, 0, 4'hF, 32'h208, 32'h0);
        m1_drive(1, 1, 0, 4'hF, 32'h308, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b10 || s_if.addr !== 32'h308) begin errors++; $display("FAIL t2_tie2 got grant=%b addr=%h want 10/308", grant, s_if.addr); end
        m0_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        m1_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t2_end got %b want 00", grant); end
    endtask

    task automatic test_hold();
        m0_drive(1, 1, 1, 4'b0001, 32'h10, 32'hAA);
        tick();
        settle();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL t3_grant got %b want 01", grant); end
        m1_drive(1, 1, 0, 4'hF, 32'h20, 32'h0);
        slave_drive(1, 32'h0);
        settle();
        checks++; if (s_if.we !== 1'b1 || s_if.sel !== 4'b0001 || s_if.dat_w !== 32'hAA) begin errors++; $display("FAIL t3_write got we=%b sel=%b dat=%h want 1/0001/aa", s_if.we, s_if.sel, s_if.dat_w); end
        checks++; if (m0_if.ack !== 1'b1 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL t3_beat1 got m0=%b m1=%b want 1/0", m0_if.ack, m1_if.ack); end
        tick();
        m0_drive(1, 1, 0, 4'hF, 32'h14, 32'h0);
        slave_drive(1, 32'h11);
        settle();
        checks++; if (grant !== 2'b01 || s_if.addr !== 32'h14 || m0_if.dat_r !== 32'h11) begin errors++; $display("FAIL t3_beat2 got grant=%b addr=%h d=%h want 01/14/11", grant, s_if.addr, m0_if.dat_r); end
        checks++; if (m1_if.ack !== 1'b0 || m1_if.dat_r !== 32'h0) begin errors++; $display("FAIL t3_m1_quiet2 got ack=%b d=%h want 0/0", m1_if.ack, m1_if.dat_r); end
        tick();
        m0_drive(1, 1, 0, 4'hF, 32'h18, 32'h0);
        slave_drive(1, 32'h22);
        settle();
        checks++; if (grant !== 2'b01 || m0_if.dat_r !== 32'h22 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL t3_beat3 got grant=%b d=%h m1ack=%b want 01/22/0", grant, m0_if.dat_r, m1_if.ack); end
        tick();
        m0_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        slave_drive(0, 32'h0);
        settle();
        checks++; if (grant !== 2'b01 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL t3_release got grant=%b m1ack=%b want 01/0", grant, m1_if.ack); end
        tick();
        settle();
        checks++; if (grant !== 2'b10 || s_if.addr !== 32'h20) begin errors++; $display("FAIL t3_m1_granted got grant=%b addr=%h want 10/20", grant, s_if.addr); end
        m1_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t3_idle got %b want 00", grant); end
    endtask

    task automatic test_timeout();
        m1_drive(1, 1, 0, 4'hF, 32'h40, 32'h0);
        tick();
        for (int c = 1; c <= 32; c++) begin
            settle();
            checks++;
            if (m1_if.err !== ((c == 16 || c == 32) ? 1'b1 : 1'b0) || m1_if.ack !== 1'b0 || m0_if.err !== 1'b0) begin
                errors++;
                $display("FAIL t4_err_cycle%0d got err=%b ack=%b m0err=%b", c, m1_if.err, m1_if.ack, m0_if.err);
            end
            tick();
        end
        settle();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL t4_hold_after_err got %b want 10", grant); end
        m1_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t4_idle got %b want 00", grant); end
        m1_drive(1, 1, 0, 4'hF, 32'h44, 32'h0);
        tick();
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) slave_drive(1, 32'h5A5A_5A5A);
            settle();
            checks++;
            if (m1_if.err !== 1'b0 || m1_if.ack !== ((c == 16) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL t4_ack_wins_cycle%0d got err=%b ack=%b", c, m1_if.err, m1_if.ack);
            end
            tick();
        end
        slave_drive(0, 32'h0);
        m1_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t4_idle2 got %b want 00", grant); end
    endtask

    task automatic test_flush();
        m1_drive(1, 1, 0, 4'hF, 32'h80, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL t5_grant got %b want 10", grant); end
        tick();
        m1_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        slave_drive(1, 32'hDEAD_BEEF);
        settle();
        checks++; if (s_if.cyc !== 1'b0 || m1_if.ack !== 1'b0 || m0_if.ack !== 1'b0) begin errors++; $display("FAIL t5_flush got cyc=%b m1ack=%b m0ack=%b want 0/0/0", s_if.cyc, m1_if.ack, m0_if.ack); end
        tick();
        settle();
        checks++; if (grant !== 2'b00 || m1_if.ack !== 1'b0 || m1_if.dat_r !== 32'h0 || m0_if.dat_r !== 32'h0) begin errors++; $display("FAIL t5_late_ack got grant=%b ack=%b d1=%h d0=%h want 00/0/0/0", grant, m1_if.ack, m1_if.dat_r, m0_if.dat_r); end
        slave_drive(0, 32'h0);
    endtask

    task automatic test_reset_mid();
        m0_drive(1, 1, 0, 4'hF, 32'h500, 32'h0);
        tick();
        m0_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL t6_pre_idle got %b want 00", grant); end
        m0_drive(1, 1, 1, 4'hF, 32'h504, 32'h77);
        tick();
        settle();
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL t6_grant got %b want 01", grant); end
        m1_drive(1, 1, 0, 4'hF, 32'h600, 32'h0);
        slave_drive(1, 32'h99);
        rst = 1'b1;
        tick();
        settle();
        checks++; if (grant !== 2'b00 || s_if.cyc !== 1'b0 || s_if.stb !== 1'b0) begin errors++; $display("FAIL t6_rst_bus got grant=%b cyc=%b stb=%b want 00/0/0", grant, s_if.cyc, s_if.stb); end
        checks++; if (s_if.addr !== 32'h0 || s_if.dat_w !== 32'h0 || s_if.we !== 1'b0) begin errors++; $display("FAIL t6_rst_fwd got addr=%h dat=%h we=%b want 0/0/0", s_if.addr, s_if.dat_w, s_if.we); end
        checks++; if (m0_if.ack !== 1'b0 || m0_if.dat_r !== 32'h0 || m1_if.ack !== 1'b0) begin errors++; $display("FAIL t6_rst_resp got a0=%b d0=%h a1=%b want 0/0/0", m0_if.ack, m0_if.dat_r, m1_if.ack); end
        rst = 1'b0;
        slave_drive(0, 32'h0);
        tick();
        settle();
        checks++; if (grant !== 2'b01 || s_if.addr !== 32'h504) begin errors++; $display("FAIL t6_tie_after_rst got grant=%b addr=%h want 01/504", grant, s_if.addr); end
        m0_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        m1_drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_hold();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
